// File: rtl/gate2_exerciser_pkg.sv
// Shared types and constants for the 2-input gate exerciser:
// FSM state encoding, vector sizing and reference truth tables.
package gate_tb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    CHECK = 2'd2
  } state_e;

  localparam int VEC_W   = 2;
  localparam int NUM_VEC = 4;

  // Bit i of each table is the expected y for {a,b} == i.
  localparam logic [NUM_VEC-1:0] TT_AND  = 4'b1000;
  localparam logic [NUM_VEC-1:0] TT_OR   = 4'b1110;
  localparam logic [NUM_VEC-1:0] TT_NAND = 4'b0111;
  localparam logic [NUM_VEC-1:0] TT_NOR  = 4'b0001;
  localparam logic [NUM_VEC-1:0] TT_XOR  = 4'b0110;
  localparam logic [NUM_VEC-1:0] TT_XNOR = 4'b1001;

  function automatic logic expected_y(input logic [NUM_VEC-1:0] tt,
                                      input logic [VEC_W-1:0]   idx);
    return tt[idx];
  endfunction

endpackage

// File: rtl/gate2_exerciser_settle_timer.sv
// Load/decrement settle counter; zero_o flags when the hold time has elapsed.
module settle_timer
  import gate_tb_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             dec_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: load has priority over decrement.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i) begin
      cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == {CNT_W{1'b0}});

endmodule

// File: rtl/gate2_exerciser.sv
// Walks a 2-input gate through all four input vectors, holds each for SETTLE
// cycles, then samples the gate output against TRUTH and reports the result.
module gate2_exerciser
  import gate_tb_pkg::*;
#(
  parameter logic [3:0] TRUTH  = TT_AND,
  parameter int         SETTLE = 2,
  parameter int         CNT_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             dut_a,
  output logic             dut_b,
  input  logic             dut_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [3:0]       fail_mask,
  output logic [VEC_W-1:0] vec_idx
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SETTLE - 1);
  localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VEC - 1);

  state_e           state_q;
  logic             dut_a_q;
  logic             dut_b_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic [3:0]       fail_mask_q;
  logic [VEC_W-1:0] vec_idx_q;

  logic [3:0]       fail_mask_d;
  logic [VEC_W-1:0] vec_idx_d;
  logic             mismatch;
  logic             tmr_load;
  logic             tmr_dec;
  logic             tmr_zero;
  logic [CNT_W-1:0] tmr_cnt;

  settle_timer #(
    .CNT_W (CNT_W)
  ) u_settle_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .dec_i      (tmr_dec),
    .load_val_i (LOAD_VAL),
    .cnt_o      (tmr_cnt),
    .zero_o     (tmr_zero)
  );

  // Compare logic and timer control derived from current state.
  always_comb begin
    mismatch    = (dut_y != expected_y(TRUTH, vec_idx_q));
    fail_mask_d = fail_mask_q;
    if (mismatch) begin
      fail_mask_d[vec_idx_q] = 1'b1;
    end else begin
      fail_mask_d = fail_mask_q;
    end
    vec_idx_d = vec_idx_q + {{(VEC_W-1){1'b0}}, 1'b1};
    tmr_load  = ((state_q == IDLE) && start) ||
                ((state_q == CHECK) && (vec_idx_q != LAST_VEC));
    tmr_dec   = (state_q == WAIT) && !tmr_zero;
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      dut_a_q     <= 1'b0;
      dut_b_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_mask_q <= 4'b0000;
      vec_idx_q   <= {VEC_W{1'b0}};
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            vec_idx_q   <= {VEC_W{1'b0}};
            dut_a_q     <= 1'b0;
            dut_b_q     <= 1'b0;
            fail_mask_q <= 4'b0000;
            pass_q      <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= WAIT;
          end else begin
            state_q <= IDLE;
          end
        end
        WAIT: begin
          if (tmr_zero) begin
            state_q <= CHECK;
          end else begin
            state_q <= WAIT;
          end
        end
        CHECK: begin
          fail_mask_q <= fail_mask_d;
          if (vec_idx_q == LAST_VEC) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            pass_q  <= (fail_mask_d == 4'b0000);
            dut_a_q <= 1'b0;
            dut_b_q <= 1'b0;
            state_q <= IDLE;
          end else begin
            vec_idx_q <= vec_idx_d;
            dut_a_q   <= vec_idx_d[1];
            dut_b_q   <= vec_idx_d[0];
            state_q   <= WAIT;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign dut_a     = dut_a_q;
  assign dut_b     = dut_b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_mask = fail_mask_q;
  assign vec_idx   = vec_idx_q;

endmodule

// File: tb/tb_gate2_exerciser.sv
// Directed bench: AND-configured exerciser against switchable gate models,
// plus an XOR-configured instance with SETTLE=1.
module tb_gate2_exerciser;
  import gate_tb_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       a, b, y;
  logic       busy, done, pass;
  logic [3:0] mask;
  logic [1:0] vidx;
  logic [1:0] mode;

  logic       start_x;
  logic       ax, bx, yx;
  logic       busy_x, done_x, pass_x;
  logic [3:0] mask_x;
  logic [1:0] vidx_x;

  int tests = 0;
  int fails = 0;

  localparam logic [1:0] M_AND  = 2'd0;
  localparam logic [1:0] M_OR   = 2'd1;
  localparam logic [1:0] M_ZERO = 2'd2;

  gate2_exerciser #(.TRUTH(TT_AND), .SETTLE(2), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dut_a(a), .dut_b(b), .dut_y(y),
    .busy(busy), .done(done), .pass(pass), .fail_mask(mask), .vec_idx(vidx)
  );

  gate2_exerciser #(.TRUTH(TT_XOR), .SETTLE(1), .CNT_W(4)) dut_x (
    .clk(clk), .rst_n(rst_n), .start(start_x), .dut_a(ax), .dut_b(bx), .dut_y(yx),
    .busy(busy_x), .done(done_x), .pass(pass_x), .fail_mask(mask_x), .vec_idx(vidx_x)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    y = 1'b0;
    case (mode)
      M_AND:   y = a & b;
      M_OR:    y = a | b;
      M_ZERO:  y = 1'b0;
      default: y = 1'b0;
    endcase
  end
  assign yx = ax ^ bx;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Full run on the SETTLE=2 instance; optional start pulse at edge pulse_e.
  task automatic run_main(input logic [3:0] exp_mask, input logic exp_pass, input int pulse_e);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("accept_busy", {3'b0, busy}, 4'd1);
    chk("accept_pass", {3'b0, pass}, 4'd0);
    chk("accept_mask", mask, 4'b0000);
    for (int e = 1; e <= 12; e++) begin
      if (e == pulse_e) start = 1'b1;
      tick();
      start = 1'b0;
      chk("done_timing", {3'b0, done}, {3'b0, (e == 12)});
      if ((e % 3) == 1) begin
        chk("ab_step", {2'b0, a, b}, 4'(e / 3));
        chk("vec_idx", {2'b0, vidx}, 4'(e / 3));
      end
    end
    chk("end_busy", {3'b0, busy}, 4'd0);
    chk("end_mask", mask, exp_mask);
    chk("end_pass", {3'b0, pass}, {3'b0, exp_pass});
    chk("end_ab", {2'b0, a, b}, 4'd0);
    tick();
    chk("done_one_cycle", {3'b0, done}, 4'd0);
    chk("mask_held", mask, exp_mask);
    chk("pass_held", {3'b0, pass}, {3'b0, exp_pass});
  endtask

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    start_x = 1'b0;
    mode    = M_AND;
    tick();
    tick();
    rst_n = 1'b1;
    chk("rst_busy", {3'b0, busy}, 4'd0);
    chk("rst_done", {3'b0, done}, 4'd0);
    chk("rst_pass", {3'b0, pass}, 4'd0);
    chk("rst_mask", mask, 4'd0);
    chk("rst_ab", {2'b0, a, b}, 4'd0);
    chk("rst_vidx", {2'b0, vidx}, 4'd0);

    mode = M_AND;  run_main(4'b0000, 1'b1, 0);
    mode = M_OR;   run_main(4'b0110, 1'b0, 0);
    mode = M_ZERO; run_main(4'b1000, 1'b0, 0);

    // XOR instance, SETTLE=1: checks at edges 2,4,6,8.
    start_x = 1'b1;
    tick();
    start_x = 1'b0;
    chk("x_accept_busy", {3'b0, busy_x}, 4'd1);
    for (int e = 1; e <= 8; e++) begin
      tick();
      chk("x_done_timing", {3'b0, done_x}, {3'b0, (e == 8)});
      if ((e % 2) == 1) chk("x_ab_step", {2'b0, ax, bx}, 4'(e / 2));
    end
    chk("x_pass", {3'b0, pass_x}, 4'd1);
    chk("x_mask", mask_x, 4'd0);
    chk("x_busy", {3'b0, busy_x}, 4'd0);

    // Reset during vector 2 aborts with no done pulse.
    mode  = M_AND;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int e = 1; e <= 7; e++) tick();
    chk("mid_vidx", {2'b0, vidx}, 4'd2);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort_busy", {3'b0, busy}, 4'd0);
    chk("abort_ab", {2'b0, a, b}, 4'd0);
    chk("abort_vidx", {2'b0, vidx}, 4'd0);
    chk("abort_mask", mask, 4'd0);
    chk("abort_pass", {3'b0, pass}, 4'd0);
    for (int e = 0; e < 8; e++) begin
      tick();
      chk("abort_no_done", {2'b0, done, busy}, 4'd0);
    end
    run_main(4'b0000, 1'b1, 0);

    // start pulsed while busy on vector 1 is ignored.
    run_main(4'b0000, 1'b1, 5);

    // start held high: back-to-back runs, mask clears on restart edge.
    mode  = M_ZERO;
    start = 1'b1;
    tick();
    for (int e = 1; e <= 12; e++) begin
      tick();
      chk("hold_done_timing", {3'b0, done}, {3'b0, (e == 12)});
    end
    chk("hold_mask1", mask, 4'b1000);
    tick();
    chk("hold_restart_busy", {3'b0, busy}, 4'd1);
    chk("hold_restart_mask", mask, 4'd0);
    chk("hold_restart_done", {3'b0, done}, 4'd0);
    chk("hold_restart_vidx", {2'b0, vidx}, 4'd0);
    start = 1'b0;
    for (int e = 1; e <= 12; e++) tick();
    chk("hold_done2", {3'b0, done}, 4'd1);
    chk("hold_mask2", mask, 4'b1000);
    chk("hold_pass2", {3'b0, pass}, 4'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
